// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: turns received SPI bytes into register-bus reads/writes with auto-increment.
// Optional: define SPI_CMD_STATUS_EN to return {err_timeout, err_overrun} during the command byte.
module spi_cmd_ctrl #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk50m,
    input  logic       rst_n,
    input  logic       cs_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_load,
    output logic [7:0] tx_data,
    output logic       reg_req,
    output logic       reg_we,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic       reg_ack,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       err_overrun,
    output logic       err_timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, WREQ, RREQ, RWAIT, ABORT} state_t;

    state_t        state;
    logic          cs_q;
    logic [6:0]    addr;
    logic [CW-1:0] tmo_cnt;
    logic          ack_now;
    logic          tmo_now;
    logic [7:0]    cs_status;

    assign ack_now  = reg_req & reg_ack;
    assign tmo_now  = reg_req & ~reg_ack & (tmo_cnt == CW'(ACK_TIMEOUT - 1));
    assign reg_addr = addr;
    assign busy     = (state != IDLE);

`ifdef SPI_CMD_STATUS_EN
    assign cs_status = {6'b0, err_timeout, err_overrun};
`else
    assign cs_status = 8'h00;
`endif

    // A pending bus request always runs to ack or timeout; CS fall only redirects the next state.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cs_q        <= 1'b0;
            addr        <= '0;
            tmo_cnt     <= '0;
            tx_load     <= 1'b0;
            tx_data     <= 8'h00;
            reg_req     <= 1'b0;
            reg_we      <= 1'b0;
            reg_wdata   <= 8'h00;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            cs_q    <= cs_active;
            tx_load <= 1'b0;

            if (reg_req) begin
                if (rx_valid)
                    err_overrun <= 1'b1;
                if (ack_now || tmo_now) begin
                    reg_req <= 1'b0;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                end
                if (tmo_now)
                    err_timeout <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs_active && !cs_q) begin
                        tx_load     <= 1'b1;
                        tx_data     <= cs_status;
                        err_overrun <= 1'b0;
                        err_timeout <= 1'b0;
                        state       <= CMD;
                    end
                end
                CMD: begin
                    if (rx_valid) begin
                        addr <= rx_data[6:0];
                        if (rx_data[7]) begin
                            state <= cs_active ? WDATA : IDLE;
                        end else begin
                            reg_req <= 1'b1;
                            reg_we  <= 1'b0;
                            state   <= RREQ;
                        end
                    end else if (!cs_active) begin
                        state <= IDLE;
                    end
                end
                WDATA: begin
                    if (rx_valid) begin
                        reg_wdata <= rx_data;
                        reg_req   <= 1'b1;
                        reg_we    <= 1'b1;
                        state     <= WREQ;
                    end else if (!cs_active) begin
                        state <= IDLE;
                    end
                end
                WREQ: begin
                    if (ack_now) begin
                        addr  <= addr + 7'd1;
                        state <= cs_active ? WDATA : IDLE;
                    end else if (tmo_now) begin
                        state <= cs_active ? ABORT : IDLE;
                    end
                end
                RREQ: begin
                    if (ack_now) begin
                        tx_data <= reg_rdata;
                        if (cs_active) begin
                            tx_load <= 1'b1;
                            state   <= RWAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (tmo_now) begin
                        state <= cs_active ? ABORT : IDLE;
                    end
                end
                RWAIT: begin
                    if (rx_valid) begin
                        addr    <= addr + 7'd1;
                        reg_req <= 1'b1;
                        reg_we  <= 1'b0;
                        state   <= RREQ;
                    end else if (!cs_active) begin
                        state <= IDLE;
                    end
                end
                ABORT: begin
                    tx_data <= 8'h00;
                    if (!cs_active)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed self-checking bench for spi_cmd_ctrl with an ack-delay bus responder and tx_load monitor.
module tb_spi_cmd_ctrl;

    logic       clk50m = 1'b0;
    logic       rst_n;
    logic       cs_active;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_load;
    logic [7:0] tx_data;
    logic       reg_req;
    logic       reg_we;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_ack;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       err_overrun;
    logic       err_timeout;

    typedef struct {
        logic       we;
        logic [6:0] addr;
        logic [7:0] data;
        int         cyc;
    } txn_t;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } txl_t;

    txn_t       bus_log[$];
    txl_t       tx_log[$];
    logic [7:0] rd_q[$];
    int         ack_delay  = -1;
    int         req_age    = 0;
    int         req_cycles = 0;
    int         cyc        = 0;
    int         checks     = 0;
    int         failures   = 0;
    logic [7:0] exp_status;

    spi_cmd_ctrl #(.ACK_TIMEOUT(16)) dut (
        .clk50m     (clk50m),
        .rst_n      (rst_n),
        .cs_active  (cs_active),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_load    (tx_load),
        .tx_data    (tx_data),
        .reg_req    (reg_req),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_ack    (reg_ack),
        .reg_rdata  (reg_rdata),
        .busy       (busy),
        .err_overrun(err_overrun),
        .err_timeout(err_timeout)
    );

    always #10 clk50m = ~clk50m;

    // Bus responder and output monitor, both on the falling edge; a negative ack_delay never acks.
    initial begin
        reg_ack   = 1'b0;
        reg_rdata = 8'h00;
        forever begin
            @(negedge clk50m);
            cyc++;
            if (tx_load)
                tx_log.push_back('{tx_data, cyc});
            if (reg_req)
                req_cycles++;
            if (!reg_req || reg_ack) begin
                reg_ack = 1'b0;
                req_age = 0;
            end else begin
                if (ack_delay >= 0 && req_age == ack_delay) begin
                    reg_ack = 1'b1;
                    if (!reg_we) begin
                        if (rd_q.size() > 0)
                            reg_rdata = rd_q.pop_front();
                        else
                            reg_rdata = 8'hEE;
                    end
                    bus_log.push_back('{reg_we, reg_addr, reg_we ? reg_wdata : reg_rdata, cyc});
                end
                req_age++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk50m);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) step();
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic clearLogs();
        bus_log.delete();
        tx_log.delete();
        req_cycles = 0;
    endtask

    initial begin
`ifdef SPI_CMD_STATUS_EN
        exp_status = 8'h02;
`else
        exp_status = 8'h00;
`endif
        rst_n     = 1'b0;
        cs_active = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        waitCycles(3);
        checkOutput("reset_outputs",
                    {3'b0, reg_req, reg_we, reg_addr, reg_wdata, tx_load, tx_data, busy, err_overrun, err_timeout},
                    32'h0);
        rst_n = 1'b1;
        step();

        $display("[TB] idle: rx_valid ignored");
        applyStimulus(8'h80);
        waitCycles(3);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_no_tx_load", tx_log.size(), 0);

        $display("[TB] test 1: single write");
        clearLogs();
        ack_delay = 3;
        cs_active = 1'b1;
        step();
        checkOutput("t1_rise_tx_load", tx_load, 1);
        checkOutput("t1_rise_tx_data", tx_data, 8'h00);
        checkOutput("t1_busy", busy, 1);
        applyStimulus(8'hB5);
        waitCycles(4);
        applyStimulus(8'h10);
        waitCycles(12);
        checkOutput("t1_write_count", bus_log.size(), 1);
        checkOutput("t1_txn", {bus_log[0].we, bus_log[0].addr, bus_log[0].data}, {1'b1, 7'h35, 8'h10});
        checkOutput("t1_req_cycles", req_cycles, 4);
        checkOutput("t1_errors", {err_overrun, err_timeout}, 2'b00);
        cs_active = 1'b0;
        waitCycles(2);
        checkOutput("t1_idle_after_cs", busy, 0);

        $display("[TB] test 2: write with address wrap");
        clearLogs();
        ack_delay = 0;
        cs_active = 1'b1;
        step();
        applyStimulus(8'hFF);
        waitCycles(4);
        applyStimulus(8'hA1);
        waitCycles(4);
        applyStimulus(8'hA2);
        waitCycles(4);
        cs_active = 1'b0;
        waitCycles(2);
        checkOutput("t2_write_count", bus_log.size(), 2);
        checkOutput("t2_txn0", {bus_log[0].we, bus_log[0].addr, bus_log[0].data}, {1'b1, 7'h7F, 8'hA1});
        checkOutput("t2_txn1", {bus_log[1].we, bus_log[1].addr, bus_log[1].data}, {1'b1, 7'h00, 8'hA2});

        $display("[TB] test 3: reads with auto-increment");
        clearLogs();
        ack_delay = 0;
        rd_q = '{8'h5A, 8'h6B, 8'h7C};
        cs_active = 1'b1;
        step();
        applyStimulus(8'h12);
        waitCycles(6);
        applyStimulus(8'h00);
        waitCycles(6);
        applyStimulus(8'h00);
        waitCycles(6);
        checkOutput("t3_read_count", bus_log.size(), 3);
        checkOutput("t3_rd0", {bus_log[0].we, bus_log[0].addr}, {1'b0, 7'h12});
        checkOutput("t3_rd1", {bus_log[1].we, bus_log[1].addr}, {1'b0, 7'h13});
        checkOutput("t3_rd2", {bus_log[2].we, bus_log[2].addr}, {1'b0, 7'h14});
        checkOutput("t3_tx_load_count", tx_log.size(), 4);
        checkOutput("t3_tx1", tx_log[1].data, 8'h5A);
        checkOutput("t3_tx2", tx_log[2].data, 8'h6B);
        checkOutput("t3_read_latency", tx_log[1].cyc - bus_log[0].cyc, 1);
        cs_active = 1'b0;
        waitCycles(2);
        checkOutput("t3_idle", busy, 0);

        $display("[TB] test 4: ack timeout");
        clearLogs();
        ack_delay = -1;
        cs_active = 1'b1;
        step();
        applyStimulus(8'h81);
        waitCycles(4);
        applyStimulus(8'h33);
        waitCycles(20);
        checkOutput("t4_req_cycles", req_cycles, 16);
        checkOutput("t4_err_timeout", err_timeout, 1);
        checkOutput("t4_req_dropped", reg_req, 0);
        checkOutput("t4_abort_busy", busy, 1);
        checkOutput("t4_no_ack", bus_log.size(), 0);
        applyStimulus(8'h44);
        waitCycles(4);
        checkOutput("t4_ignored_req", req_cycles, 16);
        checkOutput("t4_ignored_tx", tx_log.size(), 1);
        checkOutput("t4_abort_tx_data", tx_data, 8'h00);
        cs_active = 1'b0;
        waitCycles(2);
        checkOutput("t4_idle", busy, 0);
        checkOutput("t4_sticky", err_timeout, 1);
        cs_active = 1'b1;
        step();
        checkOutput("t4_status_load", tx_load, 1);
        checkOutput("t4_status_data", tx_data, exp_status);
        checkOutput("t4_flags_cleared", {err_overrun, err_timeout}, 2'b00);
        cs_active = 1'b0;
        waitCycles(2);

        $display("[TB] test 5: overrun during write");
        clearLogs();
        ack_delay = 6;
        cs_active = 1'b1;
        step();
        applyStimulus(8'hC0);
        waitCycles(4);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        waitCycles(15);
        checkOutput("t5_err_overrun", err_overrun, 1);
        checkOutput("t5_err_timeout", err_timeout, 0);
        checkOutput("t5_write_count", bus_log.size(), 1);
        checkOutput("t5_txn", {bus_log[0].we, bus_log[0].addr, bus_log[0].data}, {1'b1, 7'h40, 8'h11});
        cs_active = 1'b0;
        waitCycles(2);

        $display("[TB] test 6a: CS fall during WREQ");
        clearLogs();
        ack_delay = 5;
        cs_active = 1'b1;
        step();
        applyStimulus(8'h90);
        waitCycles(4);
        applyStimulus(8'h55);
        cs_active = 1'b0;
        waitCycles(2);
        checkOutput("t6a_req_held", reg_req, 1);
        checkOutput("t6a_busy_held", busy, 1);
        waitCycles(10);
        checkOutput("t6a_txn", {bus_log.size() == 1, bus_log[0].addr, bus_log[0].data}, {1'b1, 7'h10, 8'h55});
        checkOutput("t6a_idle", {busy, reg_req}, 2'b00);

        $display("[TB] test 6b: async reset mid-RREQ");
        clearLogs();
        ack_delay = -1;
        cs_active = 1'b1;
        step();
        applyStimulus(8'h05);
        waitCycles(3);
        checkOutput("t6b_req_pending", reg_req, 1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6b_async_reset",
                    {3'b0, reg_req, reg_we, reg_addr, reg_wdata, tx_load, tx_data, busy, err_overrun, err_timeout},
                    32'h0);
        cs_active = 1'b0;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
